// File: rtl/dac_sample_sequencer.sv
// Sample sequencer for the sigma-delta DAC modulator: small sample FIFO, clock-enable
// divider and oversampling counter that hands a new sample to the modulator every OSR strobes.
module dac_sample_sequencer #(
  parameter int CE_DIV = 4,
  parameter int OSR    = 64,
  parameter int DEPTH  = 8,
  parameter int LW     = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_res,
  input  logic              i_enable,
  input  logic              i_valid,
  input  logic [15:0]       i_sample,
  output logic              o_ready,
  output logic              o_ce,
  output logic [15:0]       o_func,
  output logic [LW-1:0]     o_level,
  output logic              o_underflow,
  input  logic              i_clr_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = $clog2(CE_DIV);
  localparam int OW = $clog2(OSR) + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_RUN
  } state_t;

  state_t           r_state;
  logic [15:0]      r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic [DW-1:0]    r_div;
  logic [OW-1:0]    r_osr;
  logic             r_ce;
  logic [15:0]      r_func;
  logic             r_underflow;
  logic             r_alive;

  logic             w_ready;
  logic             w_push;
  logic             w_flush;
  logic             w_prime_pop;
  logic             w_run_due;
  logic             w_empty;
  logic             w_pop;
  logic             w_underflow_set;
  logic             w_div_wrap;

  // r_alive keeps o_ready low while reset is held and for the reset cycle itself.
  always_comb begin
    w_ready         = r_alive && (r_level < LW'(DEPTH));
    w_push          = i_valid && w_ready;
    w_flush         = (r_state == ST_RUN) && !i_enable;
    w_prime_pop     = (r_state == ST_PRIME) && i_enable && (r_level >= LW'(DEPTH / 2));
    w_run_due       = (r_state == ST_RUN) && i_enable && (r_osr == OW'(OSR));
    w_empty         = (r_level == '0);
    w_pop           = w_prime_pop || (w_run_due && !w_empty);
    w_underflow_set = w_run_due && w_empty;
    w_div_wrap      = (r_div == DW'(CE_DIV - 1));
  end

  always_ff @(posedge i_clk) begin
    if (i_res && w_push && !w_flush) begin
      r_mem[r_wr_ptr] <= i_sample;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_res) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_div       <= '0;
      r_osr       <= '0;
      r_ce        <= 1'b0;
      r_func      <= '0;
      r_underflow <= 1'b0;
      r_alive     <= 1'b0;
    end else begin
      r_alive <= 1'b1;

      if (w_underflow_set) begin
        r_underflow <= 1'b1;
      end else if (i_clr_underflow) begin
        r_underflow <= 1'b0;
      end

      // Disable outranks push: a write in the disabling cycle is discarded with the flush.
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        r_level <= r_level + LW'(w_push) - LW'(w_pop);
      end

      case (r_state)
        ST_IDLE: begin
          r_ce   <= 1'b0;
          r_func <= '0;
          r_div  <= '0;
          r_osr  <= '0;
          if (i_enable) begin
            r_state <= ST_PRIME;
          end
        end

        ST_PRIME: begin
          r_ce  <= 1'b0;
          r_div <= '0;
          r_osr <= '0;
          if (!i_enable) begin
            r_state <= ST_IDLE;
            r_func  <= '0;
          end else if (w_prime_pop) begin
            r_func  <= r_mem[r_rd_ptr];
            r_state <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (!i_enable) begin
            r_state <= ST_IDLE;
            r_ce    <= 1'b0;
            r_func  <= '0;
            r_div   <= '0;
            r_osr   <= '0;
          end else begin
            r_div <= w_div_wrap ? '0 : r_div + DW'(1);
            r_ce  <= w_div_wrap;
            // The due cycle follows an o_ce cycle, so it never coincides with a divider wrap.
            if (w_run_due) begin
              r_osr <= '0;
            end else if (w_div_wrap) begin
              r_osr <= r_osr + OW'(1);
            end
            if (w_pop) begin
              r_func <= r_mem[r_rd_ptr];
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ready     = w_ready;
  assign o_ce        = r_ce;
  assign o_func      = r_func;
  assign o_level     = r_level;
  assign o_underflow = r_underflow;

endmodule

// File: tb/tb_dac_sample_sequencer.sv
// Scoreboard bench for dac_sample_sequencer (CE_DIV=4, OSR=4, DEPTH=8): pushed samples are
// queued and checked in order as o_func changes, with strobe cadence checked at each change.
module tb_dac_sample_sequencer;

  localparam int CE_DIV = 4;
  localparam int OSR    = 4;
  localparam int DEPTH  = 8;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic          clk;
  logic          i_res;
  logic          i_enable;
  logic          i_valid;
  logic [15:0]   i_sample;
  logic          o_ready;
  logic          o_ce;
  logic [15:0]   o_func;
  logic [LW-1:0] o_level;
  logic          o_underflow;
  logic          i_clr_underflow;

  int n_checks;
  int n_fail;
  int cyc;
  int exp_q [$];

  int          m_nchg;
  int          m_ce_cnt;
  int          m_last;
  logic [15:0] m_prev_func;
  logic        m_prev_ce;

  dac_sample_sequencer #(
    .CE_DIV(CE_DIV),
    .OSR(OSR),
    .DEPTH(DEPTH)
  ) dut (
    .i_clk(clk),
    .i_res(i_res),
    .i_enable(i_enable),
    .i_valid(i_valid),
    .i_sample(i_sample),
    .o_ready(o_ready),
    .o_ce(o_ce),
    .o_func(o_func),
    .o_level(o_level),
    .o_underflow(o_underflow),
    .i_clr_underflow(i_clr_underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic [15:0] v, input bit accepted);
    i_valid  = 1'b1;
    i_sample = v;
    if (accepted) exp_q.push_back(int'(v));
    step();
    i_valid = 1'b0;
  endtask

  // Monitor: every new o_func value must be the oldest queued sample, arriving one
  // cycle after the OSR-th strobe and never alongside a strobe.
  always @(negedge clk) begin
    int exp_v;
    if (o_func == 16'h0000) begin
      m_nchg   = 0;
      m_ce_cnt = 0;
    end else begin
      if (o_func != m_prev_func) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        check_eq("sb_func", 32'(o_func), exp_v);
        m_nchg = m_nchg + 1;
        check_eq("ce_at_change", 32'(o_ce), 0);
        if (m_nchg >= 2) begin
          check_eq("ce_before_change", 32'(m_prev_ce), 1);
          check_eq("ce_per_sample", m_ce_cnt, OSR);
          check_eq("period", cyc - m_last, (m_nchg == 2) ? OSR * CE_DIV + 1 : OSR * CE_DIV);
        end
        m_last   = cyc;
        m_ce_cnt = 0;
      end
      if (o_ce) m_ce_cnt = m_ce_cnt + 1;
    end
    m_prev_func = o_func;
    m_prev_ce   = o_ce;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ce_n;
    n_checks = 0; n_fail = 0; cyc = 0;
    m_nchg = 0; m_ce_cnt = 0; m_last = 0; m_prev_func = '0; m_prev_ce = 1'b0;
    i_res = 1'b0; i_enable = 1'b0; i_valid = 1'b1; i_sample = 16'hAAAA; i_clr_underflow = 1'b0;

    // 1. Reset with writes requested
    repeat (3) step();
    check_eq("rst_ready", 32'(o_ready), 0);
    check_eq("rst_level", 32'(o_level), 0);
    check_eq("rst_ce", 32'(o_ce), 0);
    check_eq("rst_func", 32'(o_func), 0);
    check_eq("rst_uflow", 32'(o_underflow), 0);
    i_res = 1'b1; i_valid = 1'b0;
    step();
    check_eq("ready_after_rst", 32'(o_ready), 1);
    check_eq("level_after_rst", 32'(o_level), 0);

    // 2. Prime and start
    i_enable = 1'b1;
    push(16'h1000, 1); push(16'h2000, 1); push(16'h3000, 1);
    check_eq("prime_ce", 32'(o_ce), 0);
    check_eq("prime_func", 32'(o_func), 0);
    check_eq("prime_level3", 32'(o_level), 3);
    push(16'h4000, 1);
    check_eq("prime_level4", 32'(o_level), 4);
    check_eq("prime_func_wait", 32'(o_func), 0);
    step();
    check_eq("start_func", 32'(o_func), 32'h1000);
    check_eq("start_level", 32'(o_level), 3);
    push(16'h5000, 1); check_eq("ce_c1", 32'(o_ce), 0);
    push(16'h6000, 1); check_eq("ce_c2", 32'(o_ce), 0);
    push(16'h7000, 1); check_eq("ce_c3", 32'(o_ce), 0);
    step();            check_eq("ce_c4", 32'(o_ce), 1);
    for (int i = 0; i < 3; i++) begin
      step(); check_eq("ce_gap", 32'(o_ce), 0);
    end
    step(); check_eq("ce_c8", 32'(o_ce), 1);

    // 3. Cadence (checked by monitor) over three sample periods
    repeat (50) step();
    check_eq("cadence_func", 32'(o_func), 32'h4000);
    check_eq("cadence_level", 32'(o_level), 3);

    // 4. Disable flushes; then fill past full in IDLE
    i_enable = 1'b0;
    step();
    exp_q.delete();
    check_eq("dis_level", 32'(o_level), 0);
    check_eq("dis_func", 32'(o_func), 0);
    check_eq("dis_ce", 32'(o_ce), 0);
    for (int i = 1; i <= 9; i++) begin
      push(16'(i), i <= DEPTH);
      if (i == 7) check_eq("ready_at7", 32'(o_ready), 1);
      if (i == 8) begin
        check_eq("ready_full", 32'(o_ready), 0);
        check_eq("level_full", 32'(o_level), DEPTH);
      end
    end
    check_eq("level_after_drop", 32'(o_level), DEPTH);
    i_enable = 1'b1;
    repeat (120) step();
    check_eq("sb_drained", exp_q.size(), 0);
    check_eq("full_last_func", 32'(o_func), 32'h0008);
    check_eq("full_no_uflow", 32'(o_underflow), 0);
    i_enable = 1'b0;
    step();
    exp_q.delete();
    check_eq("dis2_level", 32'(o_level), 0);

    // 5. Underflow
    i_enable = 1'b1;
    push(16'h1000, 1); push(16'h2000, 1); push(16'h3000, 1); push(16'h4000, 1);
    step();
    check_eq("uf_start_func", 32'(o_func), 32'h1000);
    repeat (64) step();
    check_eq("uf_not_yet", 32'(o_underflow), 0);
    check_eq("uf_last_func", 32'(o_func), 32'h4000);
    step();
    check_eq("uf_set", 32'(o_underflow), 1);
    check_eq("uf_hold_func", 32'(o_func), 32'h4000);
    ce_n = 0;
    repeat (8) begin
      step();
      if (o_ce) ce_n++;
    end
    check_eq("uf_ce_running", ce_n, 2);
    i_clr_underflow = 1'b1;
    step();
    i_clr_underflow = 1'b0;
    check_eq("uf_cleared", 32'(o_underflow), 0);
    repeat (6) step();
    check_eq("uf_stays_clear", 32'(o_underflow), 0);
    i_clr_underflow = 1'b1;
    step();
    i_clr_underflow = 1'b0;
    check_eq("uf_set_wins", 32'(o_underflow), 1);

    // 6. Disable mid-period with five queued samples
    for (int i = 1; i <= 5; i++) push(16'hB000 + 16'(i), 1);
    check_eq("mid_level5", 32'(o_level), 5);
    check_eq("mid_func_hold", 32'(o_func), 32'h4000);
    i_enable = 1'b0;
    step();
    exp_q.delete();
    check_eq("mid_dis_level", 32'(o_level), 0);
    check_eq("mid_dis_func", 32'(o_func), 0);
    check_eq("mid_dis_ce", 32'(o_ce), 0);
    check_eq("mid_dis_uflow_sticky", 32'(o_underflow), 1);

    // Same again, ended by reset instead of disable
    i_enable = 1'b1;
    for (int i = 1; i <= 6; i++) push(16'hC000 + 16'(i), 1);
    check_eq("rr_func", 32'(o_func), 32'hC001);
    check_eq("rr_level5", 32'(o_level), 5);
    repeat (3) step();
    i_res = 1'b0;
    step();
    exp_q.delete();
    check_eq("rr_ready", 32'(o_ready), 0);
    check_eq("rr_level", 32'(o_level), 0);
    check_eq("rr_ce", 32'(o_ce), 0);
    check_eq("rr_func0", 32'(o_func), 0);
    check_eq("rr_uflow", 32'(o_underflow), 0);
    i_res = 1'b1; i_enable = 1'b0;
    step();
    check_eq("rr_ready_after", 32'(o_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_sample_sequencer.md
Name: dac_sample_sequencer

Overview:
- Sequences sample delivery to the sigma-delta DAC modulator.
- Buffers incoming 16-bit signed samples in a small FIFO using a valid/ready handshake.
- Generates the modulator clock-enable strobe (o_ce) at a divided rate.
- Presents a new sample on o_func every OSR enable strobes; detects and flags underflow.

Parameters:
- CE_DIV, 4: i_clk cycles per o_ce strobe (>=2).
- OSR, 64: o_ce strobes per sample (oversampling ratio, >=1).
- DEPTH, 8: FIFO depth in samples, power of 2, >=2.
- LW, $clog2(DEPTH)+1: width of the level output (derived).

Ports:
- i_clk  in  1  system clock.
- i_res  in  1  synchronous active-low reset; reset acts on the rising i_clk edge while i_res==0.
- i_enable  in  1  run request.
- i_valid  in  1  sample-write request.
- i_sample  in  16  signed two's-complement sample.
- o_ready  out  1  FIFO can accept a write.
- o_ce  out  1  single-cycle clock-enable pulse to the modulator.
- o_func  out  16  current sample to the modulator.
- o_level  out  LW  FIFO occupancy, 0..DEPTH.
- o_underflow  out  1  sticky underflow flag.
- i_clr_underflow  in  1  clears o_underflow.

Behaviour:
- Reset:
  - State = IDLE; FIFO empty; o_level=0; o_ce=0; o_func=0; o_underflow=0.
  - Divider and OSR counters = 0.
  - o_ready=0 while i_res==0; o_ready=1 on the first cycle after reset.
- FIFO:
  - Write on every cycle with i_valid && o_ready.
  - o_ready = (o_level < DEPTH), combinational from the level register.
  - When full, writes are ignored and data is not corrupted.
  - Push and pop in the same cycle leave the level unchanged.
  - There is no bypass path: a pop from an empty FIFO is an underflow even if a push happens in the same cycle.
  - Pointers wrap modulo DEPTH.
- FSM:
  - IDLE: o_ce=0, o_func=0, counters held at 0, FIFO accepts writes. Go to PRIME when i_enable==1.
  - PRIME: wait for o_level >= DEPTH/2. On that edge, pop the head into o_func, clear the counters, and go to RUN. Go to IDLE if i_enable==0.
  - RUN:
    - Divider counts 0..CE_DIV-1. o_ce is registered high for exactly one cycle when the divider wraps, so the first o_ce comes CE_DIV cycles after entering RUN, then every CE_DIV cycles.
    - OSR counter increments on each o_ce. On the edge following the OSR-th o_ce, the counter resets and the next sample pops into o_func.
    - o_func is therefore stable for OSR*CE_DIV cycles and never changes in a cycle where o_ce=1.
  - Leaving RUN: i_enable==0 → IDLE on the next edge; o_ce=0, o_func=0, FIFO flushed (o_level=0).
  - Priority within one cycle: reset > disable > pop/underflow > push.
- Underflow:
  - Condition: a pop is due in RUN while the FIFO is empty.
  - o_func holds its last value, o_underflow is set, and the state stays RUN (no re-prime).
  - o_underflow clears on i_clr_underflow. If set and clear happen in the same cycle, set wins.
- Width:
  - o_func is the stored sample unmodified.
  - Divider width is $clog2(CE_DIV); OSR counter width is $clog2(OSR)+1.
- Reset mid-operation: any state returns to the full reset values on the next edge. Partial divider or OSR counts are discarded.

Test Plan (CE_DIV=4, OSR=4, DEPTH=8):
1. Reset: hold i_res=0 for 3 cycles with i_valid=1 → o_ready=0, o_level=0, o_ce=0, o_func=0. Release reset → o_ready=1 on the next cycle.
2. Prime and start:
   - i_enable=1, push 0x1000, 0x2000, 0x3000 → state PRIME, no o_ce.
   - Push 0x4000 → next edge o_func=0x1000, o_level=3.
   - First o_ce 4 cycles later, then every 4 cycles.
3. Cadence: keep FIFO fed → o_func steps 0x1000→0x2000→0x3000 every 16 cycles, each change exactly one cycle after the 4th o_ce. Check o_ce is never high when o_func changes.
4. Full: i_enable=0, push 9 samples 0x0001..0x0009 → o_level=8, o_ready=0 after the 8th push. Sample 0x0009 is dropped; the read order is 0x0001..0x0008.
5. Underflow:
   - Prime with 4 samples and stop pushing → after the 4th sample's 16-cycle period, o_func holds 0x4000 and o_underflow=1. o_ce keeps pulsing.
   - Assert i_clr_underflow for 1 cycle → o_underflow=0.
   - Assert clear in the same cycle as a new underflow → o_underflow stays 1.
6. Disable and reset mid-run:
   - Drop i_enable mid-period with o_level=5 → next edge o_ce=0, o_func=0, o_level=0, state IDLE.
   - Repeat using i_res=0 in place of i_enable → all reset values, o_underflow=0.
